game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Game-round sequencer upstream of the VGA text renderer; drives its enable, rand, GameTimeout and Points inputs.
//  After login and a difficulty pick, runs a timed round: picks the word index, scores correct decodes, counts down.
//  At timeout, freezes the score for display until the player restarts or logs out.
// PARAMETERS
//  TICK_CYCLES  25_000_000  clk cycles per 1 s countdown tick (25 MHz pixel clock)
//  T_LVL1       60          round length in seconds, level 1
//  T_LVL2       40          round length in seconds, level 2
//  T_LVL3       20          round length in seconds, level 3
//  NUM_WORDS    10          word indices 0..NUM_WORDS-1 (renderer word table size)
//  MAX_POINTS   9           score saturation value (single displayed digit)
// PORTS
//  clk          in   1  system/pixel clock
//  rst          in   1  asynchronous, active-low reset
//  LoggedIn     in   1  level: user authenticated
//  level_valid  in   1  1-cycle pulse: level_sel is valid
//  level_sel    in   2  difficulty 1..3; 0 is illegal
//  word_ok      in   1  1-cycle pulse: current word decoded correctly
//  word_bad     in   1  1-cycle pulse: current word decoded wrongly
//  restart      in   1  1-cycle pulse: replay the last level from OVER
//  enable       out  1  high in PLAY (renderer shows word)
//  rand         out  5  current word index, 0..NUM_WORDS-1
//  GameTimeout  out  1  high in OVER (renderer shows score)
//  Points       out  4  score 0..MAX_POINTS
//  secs_left    out  7  seconds remaining in round
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; enable=0, GameTimeout=0, Points=0, rand=0, secs_left=0, prescaler=0, wcnt=0, lvl=1.
//  All outputs registered. enable=(state==PLAY), GameTimeout=(state==OVER).
//  wcnt: free-running 0..NUM_WORDS-1 counter, wraps to 0, advances every cycle in all states.
//  New-word pick: rand<=wcnt; if wcnt==rand, rand<=(wcnt+1) wrapped mod NUM_WORDS. Consecutive words always differ.
//  IDLE: on LoggedIn & level_valid & level_sel!=0 -> PLAY next cycle:
//   lvl<=level_sel; secs_left<=T_LVLx; Points<=0; prescaler<=0; new-word pick.
//   level_sel==0 is ignored; state stays IDLE.
//  PLAY: prescaler counts 0..TICK_CYCLES-1 and wraps; tick = prescaler==TICK_CYCLES-1.
//   On tick: secs_left-1. On tick with secs_left==1: secs_left<=0 and go to OVER next cycle.
//   word_ok alone: Points+1, saturating at MAX_POINTS; new-word pick.
//   word_bad alone: Points unchanged; new-word pick.
//   word_ok & word_bad in the same cycle: treated as word_bad.
//   Final tick coincident with word_ok: the point is counted and the state still enters OVER.
//   level_valid and restart are ignored in PLAY.
//  OVER: Points, rand and secs_left are held.
//   restart -> PLAY with the stored lvl: Points<=0, secs_left reloaded, prescaler<=0, new-word pick.
//   level_valid is ignored in OVER.
//  LoggedIn==0 in any state -> IDLE next cycle: Points<=0, secs_left<=0, prescaler<=0. It takes priority over all other inputs.
//  Latency: accepted level_valid/restart at cycle N -> enable=1 and a valid rand at N+1.
// TESTING
//  1 Reset mid-PLAY (rst low 3 cycles) -> all outputs 0, state IDLE, immediately and asynchronously.
//  2 TICK_CYCLES=4, LoggedIn=1, level_valid with sel=3 -> enable=1 and secs_left=20 at N+1;
//    GameTimeout=1 exactly 80 cycles later; enable=0.
//  3 Twelve word_ok pulses in PLAY -> Points steps 1..9 then holds 9; rand changes on every pulse, always <10.
//  4 word_ok & word_bad in the same cycle -> Points unchanged, rand changes; word_ok on final tick -> Points+1 and OVER.
//  5 In OVER with Points=5: level_valid -> no change; restart -> PLAY, Points=0, secs_left=T_LVL3 (last level 3).
//  6 level_sel=0 in IDLE -> stays IDLE; LoggedIn dropped in PLAY -> IDLE next cycle, Points=0, enable=0.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Round sequencer for the word-decode game: level pick, timed countdown, scoring and the
// frozen score display, feeding the VGA text renderer.
module game_round_ctrl #(
   parameter int unsigned TICK_CYCLES = 25_000_000,
   parameter int unsigned T_LVL1      = 60,
   parameter int unsigned T_LVL2      = 40,
   parameter int unsigned T_LVL3      = 20,
   parameter int unsigned NUM_WORDS   = 10,
   parameter int unsigned MAX_POINTS  = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       LoggedIn,
   input  logic       level_valid,
   input  logic [1:0] level_sel,
   input  logic       word_ok,
   input  logic       word_bad,
   input  logic       restart,
   output logic       enable,
   output logic [4:0] rand_idx,   // word index; "rand" is a reserved word
   output logic       GameTimeout,
   output logic [3:0] Points,
   output logic [6:0] secs_left
);

   localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

   state_e        state_q, state_d;
   logic [1:0]    lvl_q, lvl_d;
   logic [6:0]    secs_q, secs_d;
   logic [3:0]    points_q, points_d;
   logic [4:0]    rand_q, rand_d;
   logic [4:0]    wcnt_q, wcnt_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          enable_q, enable_d;
   logic          timeout_q, timeout_d;
   logic          tick;
   logic [4:0]    pick;

   function automatic logic [4:0] wrap_inc(input logic [4:0] v);
      return (v == 5'(NUM_WORDS - 1)) ? 5'd0 : v + 5'd1;
   endfunction

   function automatic logic [6:0] lvl_time(input logic [1:0] l);
      case (l)
         2'd2:    return 7'(T_LVL2);
         2'd3:    return 7'(T_LVL3);
         default: return 7'(T_LVL1);
      endcase
   endfunction

   assign tick = (presc_q == PW'(TICK_CYCLES - 1));
   // Never repeat the word currently on screen.
   assign pick = (wcnt_q == rand_q) ? wrap_inc(wcnt_q) : wcnt_q;

   always_comb begin
      state_d  = state_q;
      lvl_d    = lvl_q;
      secs_d   = secs_q;
      points_d = points_q;
      rand_d   = rand_q;
      presc_d  = presc_q;
      wcnt_d   = wrap_inc(wcnt_q);
      if (!LoggedIn) begin
         state_d  = StIdle;
         points_d = 4'd0;
         secs_d   = 7'd0;
         presc_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (level_valid && (level_sel != 2'd0)) begin
                  state_d  = StPlay;
                  lvl_d    = level_sel;
                  secs_d   = lvl_time(level_sel);
                  points_d = 4'd0;
                  presc_d  = '0;
                  rand_d   = pick;
               end
            end
            StPlay: begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  if (secs_q <= 7'd1) begin
                     secs_d  = 7'd0;
                     state_d = StOver;
                  end else begin
                     secs_d = secs_q - 7'd1;
                  end
               end
               // A simultaneous ok/bad pair counts as a miss.
               if (word_bad) begin
                  rand_d = pick;
               end else if (word_ok) begin
                  if (points_q < 4'(MAX_POINTS)) points_d = points_q + 4'd1;
                  rand_d = pick;
               end
            end
            StOver: begin
               if (restart) begin
                  state_d  = StPlay;
                  secs_d   = lvl_time(lvl_q);
                  points_d = 4'd0;
                  presc_d  = '0;
                  rand_d   = pick;
               end
            end
            default: state_d = StIdle;
         endcase
      end
      enable_d  = (state_d == StPlay);
      timeout_d = (state_d == StOver);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         lvl_q     <= 2'd1;
         secs_q    <= 7'd0;
         points_q  <= 4'd0;
         rand_q    <= 5'd0;
         wcnt_q    <= 5'd0;
         presc_q   <= '0;
         enable_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lvl_q     <= lvl_d;
         secs_q    <= secs_d;
         points_q  <= points_d;
         rand_q    <= rand_d;
         wcnt_q    <= wcnt_d;
         presc_q   <= presc_d;
         enable_q  <= enable_d;
         timeout_q <= timeout_d;
      end
   end

   assign enable      = enable_q;
   assign GameTimeout = timeout_q;
   assign Points      = points_q;
   assign rand_idx    = rand_q;
   assign secs_left   = secs_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: a round-level reference model (cycles remaining in the round,
// words picked from the elapsed-cycle count) checked every cycle, plus literal spot checks.
module tb_game_round_ctrl;

   localparam int unsigned TICK = 4;
   localparam int unsigned NW   = 10;
   localparam int unsigned MAXP = 9;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       logged_in = 1'b0;
   logic       level_valid = 1'b0;
   logic [1:0] level_sel = 2'd0;
   logic       word_ok = 1'b0;
   logic       word_bad = 1'b0;
   logic       restart = 1'b0;
   logic       enable;
   logic       game_timeout;
   logic [4:0] rand_idx;
   logic [3:0] points;
   logic [6:0] secs_left;

   int n_cmp = 0;
   int n_fail = 0;

   // Model: 0 idle, 1 play, 2 over; m_left = clock cycles left in the round.
   int m_st, m_lvl, m_pts, m_rand, m_left, m_edges, m_w;

   game_round_ctrl #(.TICK_CYCLES(TICK)) dut (
      .clk        (clk),
      .rst        (rst),
      .LoggedIn   (logged_in),
      .level_valid(level_valid),
      .level_sel  (level_sel),
      .word_ok    (word_ok),
      .word_bad   (word_bad),
      .restart    (restart),
      .enable     (enable),
      .rand_idx   (rand_idx),
      .GameTimeout(game_timeout),
      .Points     (points),
      .secs_left  (secs_left)
   );

   always #5 clk = ~clk;

   function automatic int round_secs(input int l);
      return (l == 1) ? 60 : (l == 2) ? 40 : 20;
   endfunction

   function automatic int next_word(input int w, input int cur);
      return (w == cur) ? (w + 1) % NW : w;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_st = 0; m_lvl = 1; m_pts = 0; m_rand = 0; m_left = 0; m_edges = 0;
      end else begin
         m_w = m_edges % NW;
         m_edges++;
         if (!logged_in) begin
            m_st = 0; m_pts = 0; m_left = 0;
         end else if (m_st == 0) begin
            if (level_valid && level_sel != 2'd0) begin
               m_st = 1; m_lvl = level_sel; m_left = round_secs(m_lvl) * TICK;
               m_pts = 0; m_rand = next_word(m_w, m_rand);
            end
         end else if (m_st == 1) begin
            if (word_bad) m_rand = next_word(m_w, m_rand);
            else if (word_ok) begin
               m_pts = (m_pts + 1 > MAXP) ? MAXP : m_pts + 1;
               m_rand = next_word(m_w, m_rand);
            end
            m_left--;
            if (m_left == 0) m_st = 2;
         end else if (restart) begin
            m_st = 1; m_left = round_secs(m_lvl) * TICK;
            m_pts = 0; m_rand = next_word(m_w, m_rand);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Advance one clock and compare every output against the model.
   task automatic cyc();
      @(negedge clk);
      if (rst) begin
         chk("m_enable", enable, m_st == 1);
         chk("m_timeout", game_timeout, m_st == 2);
         chk("m_points", points, m_pts);
         chk("m_rand", rand_idx, m_rand);
         chk("m_secs", secs_left, (m_st == 1) ? (m_left + TICK - 1) / TICK : 0);
      end
   endtask

   initial begin
      int n;
      int prev;
      repeat (3) @(negedge clk);
      chk("rst_enable", enable, 0);
      chk("rst_timeout", game_timeout, 0);
      chk("rst_points", points, 0);
      chk("rst_rand", rand_idx, 0);
      chk("rst_secs", secs_left, 0);
      rst = 1'b1;
      cyc();

      // Level 0 is ignored in IDLE.
      logged_in = 1'b1; level_valid = 1'b1; level_sel = 2'd0;
      cyc();
      level_valid = 1'b0;
      chk("sel0_idle", enable, 0);

      // Level 3 round: 20 s of 4 cycles each.
      level_valid = 1'b1; level_sel = 2'd3;
      cyc();
      level_valid = 1'b0;
      chk("start_enable", enable, 1);
      chk("start_secs", secs_left, 20);
      n = 0;
      while (!game_timeout && n < 400) begin cyc(); n++; end
      chk("timeout_cycles", n, 80);
      chk("over_enable", enable, 0);
      chk("over_secs", secs_left, 0);

      // Twelve hits: score saturates at 9, word always changes.
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      chk("restart_enable", enable, 1);
      for (int k = 1; k <= 12; k++) begin
         prev = rand_idx;
         word_ok = 1'b1;
         cyc();
         word_ok = 1'b0;
         chk("sat_points", points, (k < 9) ? k : 9);
         chk("sat_rand_new", int'(rand_idx != 5'(prev)), 1);
         chk("sat_rand_range", int'(rand_idx < 5'd10), 1);
      end
      n = 0;
      while (!game_timeout && n < 200) begin cyc(); n++; end
      chk("reach_over", game_timeout, 1);

      // ok+bad together counts as a miss; then a hit on the final tick.
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      prev = rand_idx;
      word_ok = 1'b1; word_bad = 1'b1;
      cyc();
      word_ok = 1'b0; word_bad = 1'b0;
      chk("both_points", points, 0);
      chk("both_rand_new", int'(rand_idx != 5'(prev)), 1);
      for (int k = 1; k <= 4; k++) begin
         word_ok = 1'b1;
         cyc();
         word_ok = 1'b0;
         chk("hit_points", points, k);
      end
      n = 0;
      while (m_left != 1 && n < 200) begin cyc(); n++; end
      chk("final_wait", int'(n < 200), 1);
      word_ok = 1'b1;
      cyc();
      word_ok = 1'b0;
      chk("final_points", points, 5);
      chk("final_over", game_timeout, 1);

      // level_valid ignored in OVER; restart replays level 3.
      level_valid = 1'b1; level_sel = 2'd1;
      cyc();
      level_valid = 1'b0;
      chk("over_lv_timeout", game_timeout, 1);
      chk("over_lv_points", points, 5);
      restart = 1'b1;
      cyc();
      restart = 1'b0;
      chk("replay_enable", enable, 1);
      chk("replay_points", points, 0);
      chk("replay_secs", secs_left, 20);

      // Logout beats a simultaneous hit.
      word_ok = 1'b1; logged_in = 1'b0;
      cyc();
      word_ok = 1'b0;
      chk("logout_enable", enable, 0);
      chk("logout_points", points, 0);
      chk("logout_secs", secs_left, 0);

      // Asynchronous reset in the middle of a level-2 round.
      logged_in = 1'b1; level_valid = 1'b1; level_sel = 2'd2;
      cyc();
      level_valid = 1'b0;
      chk("lvl2_secs", secs_left, 40);
      word_ok = 1'b1;
      cyc();
      word_ok = 1'b0;
      repeat (5) cyc();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_enable", enable, 0);
      chk("arst_timeout", game_timeout, 0);
      chk("arst_points", points, 0);
      chk("arst_rand", rand_idx, 0);
      chk("arst_secs", secs_left, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cyc();
      chk("post_rst_idle", enable, 0);

      for (int i = 0; i < 3000; i++) begin
         logged_in   = ($urandom_range(499) != 0);
         level_valid = ($urandom_range(9) == 0);
         level_sel   = 2'($urandom_range(3));
         word_ok     = ($urandom_range(5) == 0);
         word_bad    = ($urandom_range(9) == 0);
         restart     = ($urandom_range(19) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
